layer_output_serializer: RTL and testbench

- Sequences the parallel results of one fully-connected layer into the serial input stream of the next layer.
- Collects each neuron's result on its per-neuron valid pulse.
- Once every neuron of the layer has reported, emits the results one per beat, in neuron-index order, under a valid/ready handshake.
- Sits between a layer instance's o_data_out_valid/o_data_out buses and the next layer's i_data_in_valid/i_data_in.

---
 rtl/layer_output_serializer.sv | 100 ++++++++++
 tb/tb_layer_output_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_serializer.sv
// Layer output serializer: gathers per-neuron results of one layer
// and streams them in index order over a valid/ready handshake.
module layer_output_serializer #(
  parameter int NEURONS_NUM = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NEURONS_NUM-1:0]            i_data_valid,
  input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data,
  input  logic                              i_ready,
  output logic                              o_data_valid,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int IW = (NEURONS_NUM > 1) ? $clog2(NEURONS_NUM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NEURONS_NUM - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_e;

  state_e                 state_q;
  logic [NEURONS_NUM-1:0] pend_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          idx_d;
  logic                   last_q;
  logic                   ovr_q;
  logic                   all_in_d;
  logic [DATA_WIDTH-1:0]  data_buf_q [NEURONS_NUM];

  // Frame completes when every slot is pending or arriving now
  always_comb begin
    all_in_d = &(pend_q | i_data_valid);
    idx_d    = idx_q + IW'(1);
  end

  // Collect/send FSM with slot storage and sticky overrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < NEURONS_NUM; k++) begin
        data_buf_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        COLLECT: begin
          for (int k = 0; k < NEURONS_NUM; k++) begin
            if (i_data_valid[k]) begin
              data_buf_q[k] <=
                i_data[k*DATA_WIDTH +: DATA_WIDTH];
              pend_q[k] <= 1'b1;
              if (pend_q[k]) ovr_q <= 1'b1;
            end
          end
          if (all_in_d) begin
            state_q <= SEND;
            pend_q  <= '0;
            idx_q   <= '0;
            last_q  <= (NEURONS_NUM == 1);
          end
        end
        SEND: begin
          if (|i_data_valid) ovr_q <= 1'b1;
          if (i_ready) begin
            if (last_q) begin
              state_q <= COLLECT;
              idx_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Beat data comes only from stored slots via the registered index
  always_comb begin
    o_data = '0;
    if (state_q == SEND) o_data = data_buf_q[idx_q];
  end

  assign o_data_valid = (state_q == SEND);
  assign o_busy       = (state_q == SEND);
  assign o_last       = last_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed frames, expected beats
// queued by stimulus and popped by an independent monitor.
module tb_layer_output_serializer;

  localparam int N  = 10;
  localparam int DW = 16;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    i_data_valid;
  logic [N*DW-1:0] i_data;
  logic            i_ready;
  logic            o_data_valid;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic            o_busy;
  logic            o_overrun;

  layer_output_serializer #(
    .NEURONS_NUM(N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .o_data_valid(o_data_valid),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  logic [16:0]  sb[$];
  logic [DW-1:0] cur[N];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every transferred beat must match the queue head
  always @(negedge clk) begin
    if (reset_n && o_data_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got %h expected none",
                 o_data);
      end else begin
        chk("beat", {15'd0, o_last, o_data},
            {15'd0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] salt);
    for (int k = 0; k < N; k++)
      cur[k] = DW'(16'h0100 * k + k) + salt;
  endtask

  task automatic push_frame();
    for (int k = 0; k < N; k++)
      sb.push_back({(k == N - 1), cur[k]});
  endtask

  task automatic pulse(input logic [N-1:0] m);
    i_data_valid = m;
    for (int k = 0; k < N; k++)
      i_data[k*DW +: DW] = m[k] ? cur[k] : 16'hDEAD;
    step();
    i_data_valid = '0;
    i_data       = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy || sb.size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk("idle_bound", {31'd0, (n < 60)}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    reset_n      = 1'b0;
    i_data_valid = '0;
    i_data       = '0;
    i_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, o_data_valid}, 32'd0);
    chk("rst_data", {16'd0, o_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ovr", {31'd0, o_overrun}, 32'd0);
    reset_n = 1'b1;
    step();

    // Simultaneous frame
    fill(16'h0000);
    push_frame();
    pulse('1);
    chk("sim_first_valid", {31'd0, o_data_valid}, 32'd1);
    chk("sim_first_data", {16'd0, o_data}, 32'h0000);
    repeat (9) step();
    chk("sim_last", {31'd0, o_last}, 32'd1);
    chk("sim_last_data", {16'd0, o_data}, 32'h0909);
    step();
    chk("sim_busy_drop", {31'd0, o_busy}, 32'd0);
    chk("sim_valid_drop", {31'd0, o_data_valid}, 32'd0);
    chk("sim_ovr", {31'd0, o_overrun}, 32'd0);
    wait_idle();

    // Staggered arrival
    fill(16'h1000);
    push_frame();
    pulse(10'h00F);
    step();
    pulse(10'h1F0);
    repeat (4) step();
    chk("stag_no_early", {31'd0, o_data_valid}, 32'd0);
    pulse(10'h200);
    chk("stag_first_valid", {31'd0, o_data_valid}, 32'd1);
    chk("stag_first_data", {16'd0, o_data}, 32'h1000);
    wait_idle();

    // Backpressure on beats 3 and 4
    fill(16'h0000);
    push_frame();
    pulse('1);
    len = 0;
    for (int c = 0; c < 40; c++) begin
      if (!o_busy) break;
      len++;
      i_ready = !(c == 3 || c == 4 || c == 6 || c == 7);
      if (c == 3 || c == 4 || c == 5)
        chk("bp_hold3", {16'd0, o_data}, 32'h0303);
      if (c == 6 || c == 7 || c == 8)
        chk("bp_hold4", {16'd0, o_data}, 32'h0404);
      step();
    end
    i_ready = 1'b1;
    chk("bp_len", len, 32'd14);
    wait_idle();
    chk("bp_ovr", {31'd0, o_overrun}, 32'd0);

    // Overrun during SEND
    fill(16'h0000);
    push_frame();
    pulse('1);
    repeat (5) step();
    chk("ovr_beat5", {16'd0, o_data}, 32'h0505);
    i_data_valid = 10'h004;
    i_data[2*DW +: DW] = 16'hFFFF;
    step();
    i_data_valid = '0;
    i_data       = '0;
    wait_idle();
    chk("ovr_set", {31'd0, o_overrun}, 32'd1);
    fill(16'h3000);
    push_frame();
    pulse('1);
    wait_idle();
    chk("ovr_sticky", {31'd0, o_overrun}, 32'd1);

    // Reset mid-frame
    fill(16'h4000);
    push_frame();
    pulse('1);
    repeat (6) step();
    chk("rmid_beat6", {16'd0, o_data}, 32'h4606);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("rmid_valid", {31'd0, o_data_valid}, 32'd0);
    chk("rmid_data", {16'd0, o_data}, 32'd0);
    chk("rmid_last", {31'd0, o_last}, 32'd0);
    chk("rmid_busy", {31'd0, o_busy}, 32'd0);
    chk("rmid_ovr", {31'd0, o_overrun}, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("rmid_no_stale", {31'd0, o_data_valid}, 32'd0);
    fill(16'h5000);
    push_frame();
    pulse('1);
    chk("rmid_new_first", {16'd0, o_data}, 32'h5000);
    wait_idle();

    // Duplicate in COLLECT
    chk("dup_ovr_pre", {31'd0, o_overrun}, 32'd0);
    fill(16'h6000);
    cur[3] = 16'h1111;
    pulse(10'h008);
    cur[3] = 16'h2222;
    pulse(10'h008);
    chk("dup_ovr", {31'd0, o_overrun}, 32'd1);
    chk("dup_no_send", {31'd0, o_data_valid}, 32'd0);
    push_frame();
    pulse(10'h3F7);
    wait_idle();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
